mcycle_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the processor's multi-cycle execute path. It combines control and datapath in one block: it accepts a start request, computes a WIDTH-bit multiply (full 2·WIDTH product) or divide (quotient and remainder) one bit per cycle, and reports completion with a Busy/Done handshake. New relative to the previous generation: width parameter, signed/unsigned mode, an integrated datapath, a divide-by-zero flag, fixed latency for both operations, and back-to-back issue.

---
 rtl/mcycle_unit.sv | 172 +++++++++++++++++
 tb/tb_mcycle_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// Iterative WIDTH-bit multiply/divide unit: one shift-add or restoring-divide
// step per cycle, fixed WIDTH+1 cycle latency, Busy/Done handshake.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 zero_div_q, zero_div_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result1_q, result1_d;
  logic [WIDTH-1:0]     result2_q, result2_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_mag, op2_mag;
  logic [WIDTH-1:0]     hi, lo;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_fits;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op1_neg = Signed & Operand1[WIDTH-1];
  assign op2_neg = Signed & Operand2[WIDTH-1];
  assign op1_mag = op1_neg ? -Operand1 : Operand1;
  assign op2_mag = op2_neg ? -Operand2 : Operand2;

  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

  // Multiply: lo holds the multiplier, consumed LSB first while the sum shifts in from the top.
  assign mul_addend = lo[0] ? mcand_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, hi} + {1'b0, mul_addend};

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_fits  = div_shift >= {1'b0, mcand_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mcand_q;

  assign step_acc = is_div_q
                  ? (div_fits ? {div_diff, lo[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], lo[WIDTH-2:0], 1'b0})
                  : {mul_sum, lo[WIDTH-1:1]};

  // With a zero divisor every step "fits", so hi ends as |dividend| and the
  // dividend-sign fix below restores the original Operand1 in Result2.
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -lo : lo;
  assign rem_fix  = neg_hi_q ? -hi : hi;

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    zero_div_d = zero_div_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    result1_d  = result1_q;
    result2_d  = result2_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          is_div_d   = MCycleOp;
          neg_lo_d   = op1_neg ^ op2_neg;
          neg_hi_d   = op1_neg;
          zero_div_d = MCycleOp && (Operand2 == '0);
          cnt_d      = '0;
          if (MCycleOp) begin
            mcand_d = op2_mag;
            acc_d   = {{WIDTH{1'b0}}, op1_mag};
          end else begin
            mcand_d = op1_mag;
            acc_d   = {{WIDTH{1'b0}}, op2_mag};
          end
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FINISH;
      end

      FINISH: begin
        done_d     = 1'b1;
        div_zero_d = is_div_q & zero_div_q;
        if (is_div_q) begin
          result1_d = zero_div_q ? {WIDTH{1'b1}} : quo_fix;
          result2_d = rem_fix;
        end else begin
          result1_d = prod_fix[WIDTH-1:0];
          result2_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      zero_div_q <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      result1_q  <= '0;
      result2_q  <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      zero_div_q <= zero_div_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      result1_q  <= result1_d;
      result2_q  <= result2_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Result1 = result1_q;
  assign Result2 = result2_q;
  assign DivZero = div_zero_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results and handshake timing.
module tb_mcycle_unit;

  localparam int W = 32;

  logic          clk;
  logic          Reset;
  logic          Start;
  logic          MCycleOp;
  logic          Signed;
  logic [W-1:0]  Operand1;
  logic [W-1:0]  Operand2;
  logic [W-1:0]  Result1;
  logic [W-1:0]  Result2;
  logic          Busy;
  logic          Done;
  logic          DivZero;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK      (clk),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Signed   (Signed),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full-width products and truncating division.
  function automatic void calc(input logic op, input logic sgn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] r1, output logic [W-1:0] r2,
                               output logic dz);
    logic [63:0] p;
    longint      sq, sr;
    dz = 1'b0;
    if (!op) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'd0, a} * {32'd0, b};
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == 0) begin
      r1 = '1;
      r2 = a;
      dz = 1'b1;
    end else if (sgn) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      r1 = sq[31:0];
      r2 = sr[31:0];
    end else begin
      r1 = a / b;
      r2 = a % b;
    end
  endfunction

  // Model: a countdown of cycles until the pending result appears.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dz   = 1'b0;
  logic         p_dz   = 1'b0;
  logic [W-1:0] m_r1 = '0, m_r2 = '0, p_r1 = '0, p_r2 = '0;

  always @(posedge clk) begin
    if (Reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_r1   = '0;
      m_r2   = '0;
      m_dz   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_r1   = p_r1;
          m_r2   = p_r2;
          m_dz   = p_dz;
        end
      end else if (Start) begin
        m_left = W + 1;
        calc(MCycleOp, Signed, Operand1, Operand2, p_r1, p_r2, p_dz);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy_vs_model",    64'(Busy),    64'(m_left > 0));
      check("done_vs_model",    64'(Done),    64'(m_done));
      check("result1_vs_model", 64'(Result1), 64'(m_r1));
      check("result2_vs_model", 64'(Result2), 64'(m_r2));
      check("divzero_vs_model", 64'(DivZero), 64'(m_dz));
    end
  end

  // Called just after a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input string name, input logic op, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e1, input logic [W-1:0] e2, input logic edz);
    int cycles;
    int busy_cnt;
    Start    = 1'b1;
    MCycleOp = op;
    Signed   = sgn;
    Operand1 = a;
    Operand2 = b;
    @(negedge clk);
    Start    = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    MCycleOp = ~op;
    Signed   = ~sgn;
    cycles   = 1;
    busy_cnt = Busy ? 1 : 0;
    while (!Done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (Busy) busy_cnt++;
    end
    check({name, "_latency"},  64'(cycles - 1), 64'(W + 1));
    check({name, "_busy_len"}, 64'(busy_cnt),   64'(W + 1));
    check({name, "_r1"},       64'(Result1),    64'(e1));
    check({name, "_r2"},       64'(Result2),    64'(e2));
    check({name, "_divzero"},  64'(DivZero),    64'(edz));
  endtask

  initial begin
    int cycles;
    int done_cnt;
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int done_cnt;
    Reset    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Signed   = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_busy", 64'(Busy),    64'd0);
    check("reset_done", 64'(Done),    64'd0);
    check("reset_r1",   64'(Result1), 64'd0);
    check("reset_r2",   64'(Result2), 64'd0);
    check("reset_dz",   64'(DivZero), 64'd0);
    Reset = 1'b0;
    @(negedge clk);

    // Each op starts in the previous Done cycle, so these also issue back-to-back.
    run_op("umul_max",  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("smul_m3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    run_op("umul_m3x7", 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'h00000006, 1'b0);
    run_op("smul_min2", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0);
    run_op("udiv_100_7",1'b1, 1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    run_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("sdiv_7_m2", 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
    run_op("sdiv_m100_m7", 1'b1, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,    32'hFFFFFFFE, 1'b0);
    run_op("udiv_7_100",1'b1, 1'b0, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0);
    run_op("udiv_zero", 1'b1, 1'b0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1);
    run_op("sdiv_zero", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
    run_op("sdiv_ovf",  1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);

    // Start held high all the way through, operands changed mid-operation.
    @(negedge clk);
    @(negedge clk);
    Start    = 1'b1;
    MCycleOp = 1'b0;
    Signed   = 1'b0;
    Operand1 = 32'd5;
    Operand2 = 32'd6;
    cycles   = 0;
    while (!Done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cycles == 5) begin
        Operand1 = 32'd100;
        Operand2 = 32'd9;
        MCycleOp = 1'b1;
      end
    end
    Start = 1'b0;
    check("held_latency", 64'(cycles - 1), 64'(W + 1));
    check("held_r1",      64'(Result1),    64'd30);
    check("held_r2",      64'(Result2),    64'd0);
    @(negedge clk);
    check("held_idle_after", 64'(Busy), 64'd0);

    // Reset in the middle of a divide; Start during Reset must be ignored.
    Start    = 1'b1;
    MCycleOp = 1'b1;
    Signed   = 1'b0;
    Operand1 = 32'd100;
    Operand2 = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    Reset    = 1'b1;
    Start    = 1'b1;
    Operand1 = 32'd55;
    Operand2 = 32'd5;
    @(negedge clk);
    Reset = 1'b0;
    Start = 1'b0;
    check("abort_busy", 64'(Busy),    64'd0);
    check("abort_done", 64'(Done),    64'd0);
    check("abort_r1",   64'(Result1), 64'd0);
    check("abort_r2",   64'(Result2), 64'd0);
    check("abort_dz",   64'(DivZero), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (Done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    run_op("after_abort", 1'b1, 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
